exc_ctrl: RTL and testbench

//  Exception initiator on the CP0 exception interface. Sits at the MEM/WB boundary.

---
 rtl/exc_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception initiator at MEM/WB: prioritises faults and interrupts into one CP0 event.
// Define EXC_CTRL_INT_SYNC_EN for a 2-flop ext_int synchroniser (else 1 register).
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  ext_int,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_delayslot,
  input  logic        mem_exc_adel_if,
  input  logic        mem_exc_ri,
  input  logic        mem_exc_sys,
  input  logic        mem_exc_bp,
  input  logic        mem_exc_ov,
  input  logic        mem_exc_adel_d,
  input  logic        mem_exc_ades_d,
  input  logic        mem_eret,
  input  logic [31:0] mem_addr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  Int,
  output logic        ExceptDeal,
  output logic [4:0]  EXcCode,
  output logic [31:0] Badaddr,
  output logic        DelaySlot,
  output logic [31:0] PC,
  output logic        mem_kill,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [4:0] C_INT  = 5'h00;
  localparam logic [4:0] C_ADEL = 5'h04;
  localparam logic [4:0] C_ADES = 5'h05;
  localparam logic [4:0] C_SYS  = 5'h08;
  localparam logic [4:0] C_BP   = 5'h09;
  localparam logic [4:0] C_RI   = 5'h0a;
  localparam logic [4:0] C_OV   = 5'h0c;
  localparam logic [4:0] C_ERET = 5'h0e;

  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    FLUSH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          int_pend;
  logic          any_exc;
  logic          detect;
  logic [4:0]    code;
  logic [31:0]   bad;
  logic          unused_bits;

  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:16], cp0_cause[7:0]};

  assign int_pend = (|(cp0_cause[15:8] & cp0_status[15:8]))
                  && cp0_status[0] && !cp0_status[1];
  assign any_exc  = mem_exc_adel_if | mem_exc_ri | mem_exc_sys
                  | mem_exc_bp | mem_exc_ov | mem_exc_adel_d
                  | mem_exc_ades_d | mem_eret;
  assign detect   = (state == IDLE) && mem_valid && !mem_stall
                  && (int_pend || any_exc);
  assign mem_kill = detect;

  always_comb begin
    code = C_ERET;
    bad  = '0;
    priority case (1'b1)
      int_pend:        code = C_INT;
      mem_exc_adel_if: begin
        code = C_ADEL;
        bad  = mem_pc;
      end
      mem_exc_ri:      code = C_RI;
      mem_exc_sys:     code = C_SYS;
      mem_exc_bp:      code = C_BP;
      mem_exc_ov:      code = C_OV;
      mem_exc_adel_d:  begin
        code = C_ADEL;
        bad  = mem_addr;
      end
      mem_exc_ades_d:  begin
        code = C_ADES;
        bad  = mem_addr;
      end
      default:         code = C_ERET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      ExceptDeal     <= 1'b0;
      EXcCode        <= '0;
      Badaddr        <= '0;
      DelaySlot      <= 1'b0;
      PC             <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      ExceptDeal     <= 1'b0;
      EXcCode        <= '0;
      Badaddr        <= '0;
      DelaySlot      <= 1'b0;
      PC             <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      unique case (state)
        IDLE: begin
          if (detect) begin
            state          <= COMMIT;
            flush          <= 1'b1;
            busy           <= 1'b1;
            ExceptDeal     <= 1'b1;
            EXcCode        <= code;
            Badaddr        <= bad;
            DelaySlot      <= mem_delayslot;
            PC             <= mem_pc;
            redirect_valid <= 1'b1;
            redirect_pc    <= (code == C_ERET) ? cp0_epc : EXC_VECTOR;
          end
        end
        COMMIT: begin
          if (FLUSH_CYCLES > 1) begin
            state <= FLUSH;
            cnt   <= CW'(FLUSH_CYCLES - 2);
          end else begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_CTRL_INT_SYNC_EN
  logic [5:0] int_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta <= '0;
      Int      <= '0;
    end else begin
      int_meta <= ext_int;
      Int      <= int_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Int <= '0;
    else        Int <= ext_int;
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomised bench for exc_ctrl against a cycle-level event model.
// Honours EXC_CTRL_INT_SYNC_EN for the expected interrupt latency.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  ext_int;
  logic        mem_valid, mem_stall, mem_delayslot;
  logic [31:0] mem_pc, mem_addr;
  logic        adel_if, ri, sys, bp, ov, adel_d, ades_d, eret;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic [5:0]  Int;
  logic        ExceptDeal, DelaySlot, mem_kill, flush;
  logic        redirect_valid, busy;
  logic [4:0]  EXcCode;
  logic [31:0] Badaddr, PC, redirect_pc;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .ext_int(ext_int),
    .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_pc(mem_pc),
    .mem_delayslot(mem_delayslot),
    .mem_exc_adel_if(adel_if), .mem_exc_ri(ri), .mem_exc_sys(sys),
    .mem_exc_bp(bp), .mem_exc_ov(ov), .mem_exc_adel_d(adel_d),
    .mem_exc_ades_d(ades_d), .mem_eret(eret), .mem_addr(mem_addr),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .Int(Int), .ExceptDeal(ExceptDeal), .EXcCode(EXcCode),
    .Badaddr(Badaddr), .DelaySlot(DelaySlot), .PC(PC),
    .mem_kill(mem_kill), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // model state: cycles of flush still to run (0 = idle)
  int          rem;
  logic        e_deal, e_ds, e_rv;
  logic [4:0]  e_code;
  logic [31:0] e_pc, e_bad, e_rpc;
  logic [5:0]  h1, h2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_int();
    return ((cp0_cause[15:8] & cp0_status[15:8]) != 8'h0)
           && cp0_status[0] && !cp0_status[1];
  endfunction

  function automatic logic ref_detect();
    return mem_valid && !mem_stall && (ref_int() || adel_if || ri || sys
           || bp || ov || adel_d || ades_d || eret);
  endfunction

  // first set flag in priority order decides code and faulting address
  task automatic ref_event(output logic [4:0] c, output logic [31:0] b);
    logic [4:0]  codes [9];
    logic [31:0] addrs [9];
    logic        flags [9];
    codes = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05, 5'h0e};
    addrs = '{0, mem_pc, 0, 0, 0, 0, mem_addr, mem_addr, 0};
    flags = '{ref_int(), adel_if, ri, sys, bp, ov, adel_d, ades_d, eret};
    c = 5'h1f;
    b = 32'hdead_beef;
    for (int i = 8; i >= 0; i--)
      if (flags[i]) begin
        c = codes[i];
        b = addrs[i];
      end
  endtask

  task automatic model_reset();
    rem = 0; e_deal = 0; e_ds = 0; e_rv = 0;
    e_code = 0; e_pc = 0; e_bad = 0; e_rpc = 0;
    h1 = 0; h2 = 0;
  endtask

  task automatic model_step();
    logic [4:0]  c;
    logic [31:0] b;
    h2 = h1;
    h1 = ext_int;
    if (rem == 0 && ref_detect()) begin
      ref_event(c, b);
      e_deal = 1; e_code = c; e_bad = b; e_pc = mem_pc;
      e_ds = mem_delayslot; e_rv = 1;
      e_rpc = (c == 5'h0e) ? cp0_epc : VEC;
      rem = FC;
    end else begin
      e_deal = 0; e_code = 0; e_bad = 0; e_pc = 0;
      e_ds = 0; e_rv = 0; e_rpc = 0;
      if (rem > 0) rem--;
    end
  endtask

  task automatic check_outs();
`ifdef EXC_CTRL_INT_SYNC_EN
    check("Int", 32'(Int), 32'(h2));
`else
    check("Int", 32'(Int), 32'(h1));
`endif
    check("ExceptDeal", 32'(ExceptDeal), 32'(e_deal));
    check("EXcCode", 32'(EXcCode), 32'(e_code));
    check("PC", PC, e_pc);
    check("Badaddr", Badaddr, e_bad);
    check("DelaySlot", 32'(DelaySlot), 32'(e_ds));
    check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    check("redirect_pc", redirect_pc, e_rpc);
    check("flush", 32'(flush), 32'(rem > 0));
    check("busy", 32'(busy), 32'(rem > 0));
  endtask

  // inputs already driven at the falling edge
  task automatic tick();
    #1;
    check("mem_kill", 32'(mem_kill), 32'(rem == 0 && ref_detect()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic clear_in();
    mem_valid = 1; mem_stall = 0; mem_delayslot = 0;
    mem_pc = 32'h8000_0000; mem_addr = 0;
    {adel_if, ri, sys, bp, ov, adel_d, ades_d, eret} = '0;
    cp0_status = 0; cp0_cause = 0; cp0_epc = 0;
  endtask

  task automatic rand_in();
    mem_valid     = ($urandom_range(0, 3) != 0);
    mem_stall     = ($urandom_range(0, 3) == 0);
    mem_delayslot = 1'($urandom);
    mem_pc        = $urandom & 32'hffff_fffc;
    mem_addr      = $urandom;
    adel_if = ($urandom_range(0, 15) == 0);
    ri      = ($urandom_range(0, 15) == 0);
    sys     = ($urandom_range(0, 15) == 0);
    bp      = ($urandom_range(0, 15) == 0);
    ov      = ($urandom_range(0, 15) == 0);
    adel_d  = ($urandom_range(0, 15) == 0);
    ades_d  = ($urandom_range(0, 15) == 0);
    eret    = ($urandom_range(0, 11) == 0);
    cp0_status = $urandom;
    cp0_status[1] = ($urandom_range(0, 3) == 0);
    cp0_cause  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
    cp0_epc    = $urandom;
    ext_int    = 6'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst flush", 32'(flush), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst deal", 32'(ExceptDeal), 32'h0);
    check("rst Int", 32'(Int), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    ext_int = 0;
    clear_in();
    mem_valid = 0;
    model_reset();
    #12;
    check_outs();
    @(negedge clk);
    rst_n = 1;

    // overflow, flush two cycles
    clear_in(); ov = 1; mem_pc = 32'h8000_1000; tick();
    clear_in(); mem_valid = 0; tick(); tick(); tick();

    // store misalignment in a delay slot
    clear_in(); ades_d = 1; mem_addr = 32'h8000_2003;
    mem_delayslot = 1; mem_pc = 32'h8000_1004; tick();
    clear_in(); mem_valid = 0; tick(); tick();

    // eret redirect to EPC
    clear_in(); eret = 1; cp0_epc = 32'h8000_0040; tick();
    clear_in(); mem_valid = 0; tick(); tick();

    // interrupt beats RI, then masked by EXL
    clear_in(); cp0_status = 32'h0000_FF01; cp0_cause = 32'h0000_0400;
    ri = 1; tick();
    clear_in(); mem_valid = 0; tick(); tick();
    clear_in(); cp0_status = 32'h0000_FF03; cp0_cause = 32'h0000_0400;
    ri = 1; tick();
    clear_in(); mem_valid = 0; tick(); tick();

    // stall hold, then release, then exception during flush
    clear_in(); adel_if = 1; mem_stall = 1; mem_pc = 32'h8000_2000;
    tick(); tick();
    mem_stall = 0; tick();
    clear_in(); sys = 1; tick(); tick();
    clear_in(); mem_valid = 0; tick();

    // reset mid-flush, then interrupt line latency
    clear_in(); bp = 1; tick();
    clear_in(); mem_valid = 0; tick();
    do_reset();
    ext_int = 6'h01; tick(); tick(); ext_int = 0; tick(); tick();

    for (int i = 0; i < 600; i++) begin
      rand_in();
      if ($urandom_range(0, 79) == 0) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
